// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side and shared-ALU-side signals of the two-port ALU arbiter.
interface alu_arbiter_if;
    logic        req0, req1;
    logic [1:0]  sel0, sel1;
    logic [7:0]  x0, y0, x1, y1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] result;
    logic        err;
    logic        alu_start;
    logic [1:0]  alu_sel;
    logic [7:0]  alu_x, alu_y;
    logic        alu_finish;
    logic [15:0] alu_result;
    modport slave (
        input  req0, req1, sel0, sel1, x0, y0, x1, y1, alu_finish, alu_result,
        output gnt0, gnt1, done0, done1, result, err, alu_start, alu_sel, alu_x, alu_y
    );
    modport master (
        output req0, req1, sel0, sel1, x0, y0, x1, y1, alu_finish, alu_result,
        input  gnt0, gnt1, done0, done1, result, err, alu_start, alu_sel, alu_x, alu_y
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one multi-cycle ALU between two requesters, with timeout abort.
module alu_arbiter #(
    parameter int TIMEOUT = 63
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 2);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP} state_t;
    state_t        state;
    logic          last_grant, owner, win, expired;
    logic [CW-1:0] cnt;
    // a tie goes to whoever was not served last; a lone request always wins
    assign win = (bus.req0 && bus.req1) ? !last_grant : bus.req1;
    assign expired = cnt == CW'(TIMEOUT);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            cnt           <= '0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.result    <= '0;
            bus.err       <= 1'b0;
            bus.alu_start <= 1'b0;
            bus.alu_sel   <= '0;
            bus.alu_x     <= '0;
            bus.alu_y     <= '0;
        end else begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.alu_start <= 1'b0;
            case (state)
                IDLE: if (bus.alu_finish && (bus.req0 || bus.req1)) begin
                    state         <= LAUNCH;
                    owner         <= win;
                    last_grant    <= win;
                    bus.alu_sel   <= win ? bus.sel1 : bus.sel0;
                    bus.alu_x     <= win ? bus.x1 : bus.x0;
                    bus.alu_y     <= win ? bus.y1 : bus.y0;
                    bus.gnt0      <= !win;
                    bus.gnt1      <= win;
                    bus.alu_start <= 1'b1;
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
                    cnt   <= '0;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    // expiry wins over an ALU completion seen in the same cycle
                    if (expired || (state == WAIT_DONE && bus.alu_finish)) begin
                        state      <= RESP;
                        bus.result <= expired ? 16'h0000 : bus.alu_result;
                        bus.err    <= expired;
                        bus.done0  <= !owner;
                        bus.done1  <= owner;
                    end else if (!bus.alu_finish) begin
                        state <= WAIT_DONE;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
